// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared op/state encodings and ALU code constants for alu_sequencer
package alu_seq_pkg;

    typedef enum logic [2:0] {
        OP_AND = 3'd0,
        OP_ADD = 3'd1,
        OP_LDA = 3'd2,
        OP_CMA = 3'd3,
        OP_CME = 3'd4,
        OP_CIR = 3'd5,
        OP_CIL = 3'd6,
        OP_INP = 3'd7
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT_IN,
        S_EXEC,
        S_ABORT
    } state_e;

    localparam logic [3:0] ALU_NOP = 4'b0000;
    localparam logic [3:0] ALU_AND = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_LDA = 4'b0011;
    localparam logic [3:0] ALU_CMA = 4'b1001;
    localparam logic [3:0] ALU_CME = 4'b1010;
    localparam logic [3:0] ALU_CIR = 4'b1011;
    localparam logic [3:0] ALU_CIL = 4'b1100;
    localparam logic [3:0] ALU_INP = 4'b1101;

    function automatic logic [3:0] op2code(input op_e op);
        case (op)
            OP_AND:  return ALU_AND;
            OP_ADD:  return ALU_ADD;
            OP_LDA:  return ALU_LDA;
            OP_CMA:  return ALU_CMA;
            OP_CME:  return ALU_CME;
            OP_CIR:  return ALU_CIR;
            OP_CIL:  return ALU_CIL;
            default: return ALU_INP;
        endcase
    endfunction

endpackage

// File: rtl/alu_seq_watchdog.sv
// alu_seq_watchdog: loadable down-counter that flags a FETCH that ran CYCLES cycles
// Ports: clk, rst_n (async active-low); start loads and arms the counter,
//        clear disarms it, expired is high in the CYCLES-th armed cycle.
module alu_seq_watchdog #(
    parameter int CYCLES = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic clear,
    output logic expired
);

    localparam int W = $clog2(CYCLES + 1);

    logic [W-1:0] cnt_q;
    logic         act_q;

    // Loading CYCLES-1 makes the first armed cycle count as cycle 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            act_q <= 1'b0;
        end else if (start) begin
            cnt_q <= W'(CYCLES - 1);
            act_q <= 1'b1;
        end else if (clear) begin
            act_q <= 1'b0;
        end else if (act_q && cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign expired = act_q && cnt_q == '0;

endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle controller sequencing the accumulator ALU per instruction
// Ports: req_valid/req_ready/req_op/req_addr instruction request; mem_rd_req/mem_addr/
//        mem_rd_ack operand read handshake; dr_load, alu_code, ac_load, e_load register
//        strobes; alu_ff_en E-change enable; fgi/fgi_clr input flag; done/err pulses.
// Optional macro ALU_SEQ_TIMEOUT_EN: aborts a FETCH after TIMEOUT_CYCLES cycles without ack.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int ADDR_W         = 12,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              mem_rd_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_rd_ack,
    output logic              dr_load,
    output logic [3:0]        alu_code,
    input  logic              alu_ff_en,
    output logic              ac_load,
    output logic              e_load,
    input  logic              fgi,
    output logic              fgi_clr,
    output logic              done,
    output logic              err
);

    state_e            state_q;
    op_e               op_q;
    logic [ADDR_W-1:0] addr_q;
    logic              expired;
    logic              exec;

    wire accept = req_valid && req_ready;

`ifdef ALU_SEQ_TIMEOUT_EN
    alu_seq_watchdog #(.CYCLES(TIMEOUT_CYCLES)) u_wd (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (accept && req_op <= 3'd2),
        .clear   (state_q != S_FETCH || mem_rd_ack),
        .expired (expired)
    );
`else
    // FETCH never times out; the parameter only matters with the watchdog.
    assign expired = 1'b0 && (TIMEOUT_CYCLES > 0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= OP_AND;
            addr_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (accept) begin
                    op_q    <= op_e'(req_op);
                    addr_q  <= req_addr;
                    state_q <= req_op <= 3'd2 ? S_FETCH : req_op == 3'd7 ? S_WAIT_IN : S_EXEC;
                end
                // An ack coinciding with expiry still completes normally.
                S_FETCH:   state_q <= mem_rd_ack ? S_EXEC : expired ? S_ABORT : S_FETCH;
                S_WAIT_IN: state_q <= fgi ? S_EXEC : S_WAIT_IN;
                default:   state_q <= S_IDLE;
            endcase
        end
    end

    assign exec       = state_q == S_EXEC;
    // Gated by rst_n so the decoder sees no ready while reset is held.
    assign req_ready  = rst_n && state_q == S_IDLE;
    assign mem_rd_req = state_q == S_FETCH;
    assign mem_addr   = addr_q;
    assign dr_load    = mem_rd_req && mem_rd_ack;
    assign alu_code   = exec ? op2code(op_q) : ALU_NOP;
    // CME leaves the ALU output undefined, so AC must not be loaded.
    assign ac_load    = exec && op_q != OP_CME;
    assign e_load     = exec && alu_ff_en;
    assign fgi_clr    = exec && op_q == OP_INP;
    assign done       = exec;
    assign err        = state_q == S_ABORT;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed self-checking bench for alu_sequencer
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [11:0] req_addr;
    logic        mem_rd_req;
    logic [11:0] mem_addr;
    logic        mem_rd_ack;
    logic        dr_load;
    logic [3:0]  alu_code;
    logic        alu_ff_en;
    logic        ac_load;
    logic        e_load;
    logic        fgi;
    logic        fgi_clr;
    logic        done;
    logic        err;

    int n_asrt = 0;
    int n_fail = 0;
    int n_acl  = 0;
    int acl0;

    alu_sequencer #(.ADDR_W(12), .TIMEOUT_CYCLES(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_addr   (req_addr),
        .mem_rd_req (mem_rd_req),
        .mem_addr   (mem_addr),
        .mem_rd_ack (mem_rd_ack),
        .dr_load    (dr_load),
        .alu_code   (alu_code),
        .alu_ff_en  (alu_ff_en),
        .ac_load    (ac_load),
        .e_load     (e_load),
        .fgi        (fgi),
        .fgi_clr    (fgi_clr),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (ac_load) n_acl++;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_asrt++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL sim_timeout: got running expected finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_op = 3'd0; req_addr = '0;
        mem_rd_ack = 1'b0; alu_ff_en = 1'b0; fgi = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_ready", req_ready, 0);
        check("rst_code", alu_code, 0);
        check("rst_rdreq", mem_rd_req, 0);
        @(negedge clk); rst_n = 1'b1; #1;
        check("rel_ready", req_ready, 1);

        // ADD 0x05A, ack after 3 wait cycles
        @(negedge clk); req_valid = 1; req_op = 3'd1; req_addr = 12'h05A; alu_ff_en = 1; #1;
        @(negedge clk); req_valid = 0; #1;
        check("add_rdreq", mem_rd_req, 1);
        check("add_addr", mem_addr, 16'h05A);
        check("add_nodr", dr_load, 0);
        check("add_busy", req_ready, 0);
        repeat (2) begin
            @(negedge clk); #1;
            check("add_wait", {mem_rd_req, dr_load, done}, 3'b100);
        end
        @(negedge clk); mem_rd_ack = 1; #1;
        check("add_drload", dr_load, 1);
        @(negedge clk); mem_rd_ack = 0; #1;
        check("add_code", alu_code, 4'b0010);
        check("add_strb", {ac_load, e_load, done, mem_rd_req}, 4'b1110);
        @(negedge clk); #1;
        check("add_idle", {req_ready, done, alu_code}, {2'b10, 4'b0000});

        // stray ack while idle
        mem_rd_ack = 1; #1;
        check("idle_ack", dr_load, 0);
        mem_rd_ack = 0;

        // AND with ack in the first FETCH cycle: minimum latency
        @(negedge clk); req_valid = 1; req_op = 3'd0; req_addr = 12'hFFF; alu_ff_en = 0; #1;
        @(negedge clk); req_valid = 0; mem_rd_ack = 1; #1;
        check("and_dr", {dr_load, mem_addr}, {1'b1, 12'hFFF});
        @(negedge clk); mem_rd_ack = 0; #1;
        check("and_exec", {alu_code, ac_load, e_load, done}, {4'b0001, 3'b101});

        // LDA then CMA through the same path
        @(negedge clk); req_valid = 1; req_op = 3'd2; req_addr = 12'h321; #1;
        @(negedge clk); req_valid = 0; mem_rd_ack = 1; #1;
        @(negedge clk); mem_rd_ack = 0; #1;
        check("lda_exec", {alu_code, ac_load, e_load, done}, {4'b0011, 3'b101});
        @(negedge clk); req_valid = 1; req_op = 3'd3; #1;
        @(negedge clk); req_valid = 0; #1;
        check("cma_exec", {alu_code, ac_load, e_load, done, mem_rd_req}, {4'b1001, 4'b1010});

        // CME: E only, AC untouched
        @(negedge clk); req_valid = 1; req_op = 3'd4; alu_ff_en = 1; acl0 = n_acl; #1;
        @(negedge clk); req_valid = 0; #1;
        check("cme_exec", {alu_code, ac_load, e_load, done}, {4'b1010, 3'b011});
        @(negedge clk); #1;
        check("cme_ac", n_acl[15:0], acl0[15:0]);
        check("cme_idle", req_ready, 1);

        // INP waiting 5 cycles on fgi
        @(negedge clk); req_valid = 1; req_op = 3'd7; alu_ff_en = 0; fgi = 0; #1;
        repeat (5) begin
            @(negedge clk); req_valid = 0; #1;
            check("inp_wait", {req_ready, done, fgi_clr, alu_code, mem_rd_req}, 8'h00);
        end
        @(negedge clk); fgi = 1; #1;
        check("inp_fgi", done, 0);
        @(negedge clk); fgi = 0; #1;
        check("inp_exec", {alu_code, ac_load, fgi_clr, done, e_load}, {4'b1101, 4'b1110});
        @(negedge clk); #1;
        check("inp_idle", {req_ready, fgi_clr}, 2'b10);

        // back-to-back CIR, CIL with req_valid held
        @(negedge clk); req_valid = 1; req_op = 3'd5; alu_ff_en = 1; #1;
        @(negedge clk); req_op = 3'd6; #1;
        check("cir_exec", {alu_code, done, ac_load, e_load, req_ready}, {4'b1011, 4'b1110});
        @(negedge clk); #1;
        check("b2b_gap", {done, req_ready}, 2'b01);
        @(negedge clk); req_valid = 0; #1;
        check("cil_exec", {alu_code, done, ac_load, e_load}, {4'b1100, 3'b111});
        @(negedge clk); #1;
        check("cil_idle", {done, req_ready}, 2'b01);

        // reset in the middle of FETCH
        @(negedge clk); req_valid = 1; req_op = 3'd1; req_addr = 12'h123; #1;
        @(negedge clk); req_valid = 0; #1;
        check("rf_rdreq", mem_rd_req, 1);
        #2 rst_n = 0; #1;
        check("rf_async", {mem_rd_req, req_ready, done, ac_load, e_load, dr_load, fgi_clr, err}, 8'h00);
        check("rf_outs", {alu_code, mem_addr}, 16'h0000);
        @(negedge clk); rst_n = 1; mem_rd_ack = 1; #1;
        check("rf_ready", {req_ready, dr_load}, 2'b10);
        @(negedge clk); mem_rd_ack = 0; #1;
        check("rf_late", {done, ac_load, mem_rd_req}, 3'b000);

`ifdef ALU_SEQ_TIMEOUT_EN
        // no ack: abort after 8 FETCH cycles
        @(negedge clk); req_valid = 1; req_op = 3'd1; req_addr = 12'h0AA; acl0 = n_acl; #1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk); req_valid = 0; #1;
            check("to_fetch", {mem_rd_req, err}, 2'b10);
        end
        @(negedge clk); #1;
        check("to_abort", {err, mem_rd_req, ac_load, e_load, done}, 5'b10000);
        @(negedge clk); #1;
        check("to_idle", {req_ready, err}, 2'b10);
        check("to_noac", n_acl[15:0], acl0[15:0]);

        // ack in the 8th cycle wins over expiry
        @(negedge clk); req_valid = 1; req_op = 3'd1; #1;
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk); req_valid = 0; #1;
        end
        @(negedge clk); mem_rd_ack = 1; #1;
        check("to8_dr", {dr_load, err}, 2'b10);
        @(negedge clk); mem_rd_ack = 0; #1;
        check("to8_exec", {done, ac_load, err, alu_code}, {3'b110, 4'b0010});
        @(negedge clk); #1;
        check("to8_idle", {req_ready, err}, 2'b10);
`else
        // without the watchdog a long FETCH just keeps waiting
        @(negedge clk); req_valid = 1; req_op = 3'd1; req_addr = 12'h0AA; #1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk); req_valid = 0; #1;
        end
        check("long_fetch", {mem_rd_req, err}, 2'b10);
        @(negedge clk); mem_rd_ack = 1; #1;
        @(negedge clk); mem_rd_ack = 0; #1;
        check("long_exec", {done, err, alu_code}, {2'b10, 4'b0010});
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Multi-cycle controller that sequences the 16-bit accumulator ALU for memory-reference and register-reference instructions. It accepts one instruction request at a time and, for memory operands, fetches the operand into DR through a read handshake. It then drives `alu_code` for exactly one execute cycle and asserts the AC and E load strobes. It sits between the instruction decoder and the ALU/AC/E/DR registers.

## Interface
- `ADDR_W`, 12: memory address width.
- `TIMEOUT_CYCLES`, 64: maximum FETCH cycles before abort; used only with the timeout feature.
- `clk  in  1`: single clock; all state changes on rising edge.
- `rst_n  in  1`: reset, asynchronous and active-low.
- `req_valid  in  1`: instruction request valid.
- `req_ready  out  1`: high only in IDLE; a request is accepted when `req_valid & req_ready`.
- `req_op  in  3`: 0 AND, 1 ADD, 2 LDA, 3 CMA, 4 CME, 5 CIR, 6 CIL, 7 INP.
- `req_addr  in  ADDR_W`: operand address; used for ops 0–2 only.
- `mem_rd_req  out  1`: memory read request; held until ack.
- `mem_addr  out  ADDR_W`: captured `req_addr`; stable while `mem_rd_req` is high.
- `mem_rd_ack  in  1`: read data valid on the DR input bus this cycle.
- `dr_load  out  1`: load DR from the bus; equals `mem_rd_ack` while in FETCH.
- `alu_code  out  4`: ALU operation code; 4'b0000 outside EXEC.
- `alu_ff_en  in  1`: E-change enable from the ALU.
- `ac_load  out  1`: load AC from the ALU output.
- `e_load  out  1`: load E from the ALU carry output.
- `fgi  in  1`: input-register-full flag.
- `fgi_clr  out  1`: clear FGI; pulses in the EXEC cycle of INP.
- `done  out  1`: one-cycle completion pulse.
- `err  out  1`: one-cycle abort pulse; tied 0 without the timeout feature.

## Operation
- Five states: IDLE, FETCH, WAIT_IN, EXEC, ABORT. Reset state is IDLE.
- On acceptance, register `req_op` and `req_addr`. Next state:
  - ops 0–2 → FETCH
  - op 7 → WAIT_IN
  - others → EXEC
- **FETCH**
  - `mem_rd_req=1`.
  - On `mem_rd_ack`: `dr_load=1`, next state EXEC.
  - `mem_rd_ack` outside FETCH is ignored.
- **WAIT_IN**: stay until `fgi=1`, then go to EXEC. If `fgi` is already 1 on entry, leave after one cycle.
- **EXEC** lasts exactly one cycle. `alu_code` mapping:

  | Op | `alu_code` |
  |---|---|
  | AND | 0001 |
  | ADD | 0010 |
  | LDA | 0011 |
  | CMA | 1001 |
  | CME | 1010 |
  | CIR | 1011 |
  | CIL | 1100 |
  | INP | 1101 |

- EXEC strobes:
  - `ac_load=1` for all ops except CME. The ALU output is undefined for CME and must never be loaded.
  - `e_load = alu_ff_en`. Asserted for ADD, CME, CIR and CIL only.
  - `done=1`.
  - `fgi_clr=1` if op is INP.
  - Next state IDLE.
- Outputs are decoded combinationally from the registered state and op only; no input-to-output path except `dr_load` and `e_load`.
- Reset at any time forces IDLE immediately.
  - All outputs go 0: `req_ready=0` during reset, 1 after release; `alu_code=0000`; `mem_rd_req` drops.
  - A pending memory read is abandoned; a late ack is ignored.

## Timing
- Request accepted at edge T.
- Register ops (CMA, CME, CIR, CIL): EXEC in cycle T+1, `req_ready` again at T+2. Back-to-back throughput is 2 cycles.
- Memory ops: FETCH from T+1. An ack in cycle T+1+k gives EXEC at T+2+k; minimum latency 2 cycles to EXEC.
- INP: EXEC one cycle after the first cycle in WAIT_IN with `fgi=1`.
- `done`, `ac_load` and `e_load` coincide; AC and E update at the end of the EXEC cycle.
- With `req_valid` held high, the next request is accepted in the IDLE cycle immediately after EXEC.

## Configuration
- Macro `ALU_SEQ_TIMEOUT_EN`.
- **Defined:**
  - A counter runs in FETCH.
  - After `TIMEOUT_CYCLES` cycles without ack: go to ABORT, drop `mem_rd_req`, pulse `err` for one cycle, return to IDLE.
  - No AC or E load occurs on abort.
  - An ack in the same cycle as expiry wins (normal EXEC).
- **Undefined:** FETCH waits indefinitely, `err` is constant 0, ABORT is unreachable.

## Structure
- Package `alu_seq_pkg`:
  - op enum (3-bit)
  - state enum
  - ALU code constants (`ALU_AND`…`ALU_INP`, `ALU_NOP=4'b0000`)
  - op-to-code function
- Sub-module `alu_seq_watchdog`: loadable down-counter with `start`/`clear`/`expired`. Instantiated only under `ALU_SEQ_TIMEOUT_EN`.

## Test plan
- **ADD addr 0x05A:** ack after 3 wait cycles.
  - Requires: `mem_addr=0x05A`, `dr_load` in ack cycle.
  - Next cycle: `alu_code=0010`, `ac_load=1`, `e_load=1` (with `alu_ff_en=1`), `done=1`.
  - `req_ready` high the cycle after.
- **CME:** `alu_code=1010`, `ac_load=0`, `e_load=1`, `done` at T+1. The AC model is unchanged.
- **INP with `fgi=0` for 5 cycles, then 1:** stays in WAIT_IN. Then EXEC with `alu_code=1101`, `ac_load=1`, `fgi_clr=1`.
- **Back-to-back CIR, CIL with `req_valid` held:** EXEC cycles at T+1 and T+3, codes 1011 then 1100; `done` pulses 2 cycles apart.
- **Reset mid-FETCH:** assert `rst_n=0` asynchronously.
  - `mem_rd_req` drops without waiting for an edge; all outputs 0.
  - After release: `req_ready=1`. A stray ack produces no `dr_load`.
- **With `ALU_SEQ_TIMEOUT_EN`, `TIMEOUT_CYCLES=8`:**
  - No ack: `err` pulses after 8 FETCH cycles, no `ac_load`, back to IDLE.
  - Ack in the 8th cycle: normal completion, `err=0`.
